serial_adder_16: RTL and testbench

//  Bit-serial WIDTH-bit adder: the addition counterpart of the 16-bit ripple subtractor.

---
 rtl/arith_pkg.sv | 10 +
 rtl/full_adder_cell.sv | 16 +
 rtl/serial_adder_16.sv | 99 +++++++++
 tb/tb_serial_adder_16.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic-library types: serial datapath FSM state encoding.
package arith_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder cell, companion to the full-subtractor cell.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;

    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);

endmodule

// File: rtl/serial_adder_16.sv
// Bit-serial adder: one bit per clock, LSB first, (WIDTH+1)-bit unsigned result.
module serial_adder_16
    import arith_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   sum
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-2:0]   res_q, res_d;
    logic [WIDTH-1:0]   res_shift;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH:0]     sum_q, sum_d;
    logic               fa_s, fa_co;

    full_adder_cell u_fa (
        .a  (a_q[0]),
        .b  (b_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    // Only WIDTH-1 result bits need storing; the final bit goes straight into sum.
    assign res_shift = {fa_s, res_q};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                res_d   = res_shift[WIDTH-1:1];
                carry_d = fa_co;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    sum_d   = {fa_co, res_shift};
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign sum  = sum_q;

endmodule

// File: tb/tb_serial_adder_16.sv
// Scoreboard bench for serial_adder_16 at WIDTH=16 and WIDTH=8.
module tb_serial_adder_16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst16, start16, cin16, busy16, done16;
    logic [15:0] a16, b16;
    logic [16:0] sum16;
    logic        rst8, start8, cin8, busy8, done8;
    logic [7:0]  a8, b8;
    logic [8:0]  sum8;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [16:0] exp16[$];
    int          t16[$];
    logic [8:0]  exp8[$];
    int          t8[$];
    int busy_run16 = 0, done_cnt16 = 0;
    int busy_run8 = 0, done_cnt8 = 0;

    serial_adder_16 #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst16), .start(start16), .a(a16), .b(b16), .cin(cin16),
        .busy(busy16), .done(done16), .sum(sum16)
    );

    serial_adder_16 #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got=%0h required=%0h", name, got, req);
        end
    endtask

    always @(negedge clk) begin : mon16
        logic [16:0] e;
        int ts;
        if (rst16) begin
            busy_run16 = 0;
        end else begin
            if (busy16) busy_run16++;
            if (done16) begin
                done_cnt16++;
                if (exp16.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_done16 got sum=%0h required no done", sum16);
                end else begin
                    e  = exp16.pop_front();
                    ts = t16.pop_front();
                    chk("sum16", 32'(sum16), 32'(e));
                    chk("latency16", 32'(cyc - ts), 32'd16);
                    chk("busy_len16", 32'(busy_run16), 32'd16);
                end
                busy_run16 = 0;
            end
        end
    end

    always @(negedge clk) begin : mon8
        logic [8:0] e;
        int ts;
        if (rst8) begin
            busy_run8 = 0;
        end else begin
            if (busy8) busy_run8++;
            if (done8) begin
                done_cnt8++;
                if (exp8.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_done8 got sum=%0h required no done", sum8);
                end else begin
                    e  = exp8.pop_front();
                    ts = t8.pop_front();
                    chk("sum8", 32'(sum8), 32'(e));
                    chk("latency8", 32'(cyc - ts), 32'd8);
                    chk("busy_len8", 32'(busy_run8), 32'd8);
                end
                busy_run8 = 0;
            end
        end
    end

    task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic c, input bit expect_it);
        @(negedge clk);
        a16 = a; b16 = b; cin16 = c; start16 = 1'b1;
        if (expect_it) begin
            exp16.push_back(17'(a) + 17'(b) + 17'(c));
            t16.push_back(cyc + 1);
        end
        @(negedge clk);
        start16 = 1'b0;
        a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
    endtask

    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c);
        @(negedge clk);
        a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
        exp8.push_back(9'(a) + 9'(b) + 9'(c));
        t8.push_back(cyc + 1);
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    endtask

    task automatic wait_idle16();
        int n = 0;
        while (exp16.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp16.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout16 got pending=%0d required 0", exp16.size());
            exp16.delete();
            t16.delete();
        end
    endtask

    task automatic wait_idle8();
        int n = 0;
        while (exp8.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp8.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout8 got pending=%0d required 0", exp8.size());
            exp8.delete();
            t8.delete();
        end
    endtask

    initial begin
        rst16 = 1'b1; start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
        rst8  = 1'b1; start8  = 1'b0; a8  = '0; b8  = '0; cin8  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy16", 32'(busy16), 32'd0);
        chk("rst_done16", 32'(done16), 32'd0);
        chk("rst_sum16", 32'(sum16), 32'd0);
        chk("rst_busy8", 32'(busy8), 32'd0);
        chk("rst_sum8", 32'(sum8), 32'd0);
        rst16 = 1'b0;
        rst8  = 1'b0;

        fork
            begin
                int base, n;
                issue16(16'h0001, 16'h0001, 1'b0, 1'b1); wait_idle16();
                issue16(16'hFFFF, 16'h0001, 1'b0, 1'b1); wait_idle16();
                issue16(16'hFFFF, 16'hFFFF, 1'b1, 1'b1); wait_idle16();
                issue16(16'h0000, 16'h0000, 1'b1, 1'b1); wait_idle16();

                // start re-pulsed during RUN and during DONE must both be ignored
                base = done_cnt16;
                issue16(16'h1234, 16'h1111, 1'b0, 1'b1);
                repeat (3) @(negedge clk);
                a16 = 16'hFFFF; start16 = 1'b1;
                @(negedge clk);
                start16 = 1'b0;
                n = 0;
                while (!done16 && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                a16 = 16'hFFFF; start16 = 1'b1;
                @(negedge clk);
                start16 = 1'b0;
                repeat (20) @(negedge clk);
                chk("t4_one_done", 32'(done_cnt16 - base), 32'd1);
                chk("t4_busy_low", 32'(busy16), 32'd0);
                chk("t4_sum_hold", 32'(sum16), 32'h02345);
                wait_idle16();

                // abort at RUN cycle 8
                issue16(16'h5555, 16'h2222, 1'b0, 1'b0);
                repeat (7) @(negedge clk);
                rst16 = 1'b1; start16 = 1'b1;
                @(negedge clk);
                chk("t5_busy", 32'(busy16), 32'd0);
                chk("t5_done", 32'(done16), 32'd0);
                chk("t5_sum", 32'(sum16), 32'd0);
                rst16 = 1'b0; start16 = 1'b0;
                repeat (2) @(negedge clk);
                chk("t5_rst_start_ignored", 32'(busy16), 32'd0);
                issue16(16'h0003, 16'h0004, 1'b0, 1'b1); wait_idle16();

                for (int i = 0; i < 2000; i++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    issue16(16'($urandom), 16'($urandom), 1'($urandom), 1'b1);
                    wait_idle16();
                end
            end
            begin
                for (int j = 0; j < 2000; j++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    issue8(8'($urandom), 8'($urandom), 1'($urandom));
                    wait_idle8();
                end
                issue8(8'hFF, 8'hFF, 1'b1); wait_idle8();
            end
        join

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
